reg_writeback_unit: RTL

// - Writer side of the 32x32 register file: owns the single write port (rf_we/rf_waddr/rf_wdata).
// - Merges results from the ALU/load pipeline and the multi-cycle mult/div unit.
// - Keeps a pending-write scoreboard so decode can stall on multi-cycle destinations.
// - Outputs are registered on posedge clk. The register file captures them on the following negedge.

---
 rtl/mips_wb_pkg.sv | 16 +
 rtl/reg_writeback_unit_if.sv | 40 ++++
 rtl/wb_result_fifo.sv | 57 +++++
 rtl/reg_writeback_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared types and sizes for the register-file
// writeback path.
package mips_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Result/issue/register-file bundle between the
// pipeline (master) and the writeback unit (slave).
interface reg_writeback_unit_if;
  import mips_wb_pkg::*;

  logic                alu_valid;
  logic                alu_ready;
  logic [REG_W-1:0]    alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                md_valid;
  logic                md_ready;
  logic [REG_W-1:0]    md_rd;
  logic [DATA_W-1:0]   md_data;
  logic                iss_valid;
  logic [REG_W-1:0]    iss_rd;
  logic                rf_we;
  logic [REG_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [NUM_REGS-1:0] busy;
  logic                sb_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output md_valid, md_rd, md_data,
    output iss_valid, iss_rd,
    input  alu_ready, md_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy, sb_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  md_valid, md_rd, md_data,
    input  iss_valid, iss_rd,
    output alu_ready, md_ready,
    output rf_we, rf_waddr, rf_wdata,
    output busy, sb_err
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering mult/div results
// until the writeback arbiter can retire them.
module wb_result_fifo
  import mips_wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  wb_req_t       req_i,
  input  logic          pop_i,
  output wb_req_t       head_o,
  output logic [CW-1:0] count_o
);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= req_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Single register-file write port: ALU/md arbiter,
// md starvation guard and pending-write scoreboard.
module reg_writeback_unit
  import mips_wb_pkg::*;
#(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  reg_writeback_unit_if.slave wb
);

  localparam int CW  = $clog2(MD_DEPTH) + 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);

  wb_req_t             head;
  wb_req_t             push_req;
  wb_req_t             sel;
  logic [CW-1:0]       count;
  logic                has_md;
  logic                starve;
  logic                push;
  logic                pop;
  logic                alu_take;
  logic                do_wr;
  logic                md_wr;

  logic [AGW-1:0]      age_q, age_d;
  logic                we_q, we_d;
  logic [REG_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic                err_q, err_d;

  assign has_md = (count != '0);
  assign starve = has_md
               && (age_q >= AGW'(STARVE_LIMIT));

  assign wb.alu_ready = !starve;
  assign wb.md_ready  = !rst
                     && (count < CW'(MD_DEPTH));

  assign push          = wb.md_valid && wb.md_ready;
  assign push_req.rd   = wb.md_rd;
  assign push_req.data = wb.md_data;

  wb_result_fifo #(
    .DEPTH (MD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .req_i   (push_req),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    sel      = '0;
    pop      = 1'b0;
    alu_take = 1'b0;
    priority case (1'b1)
      starve: begin
        pop = 1'b1;
        sel = head;
      end
      wb.alu_valid: begin
        alu_take = 1'b1;
        sel.rd   = wb.alu_rd;
        sel.data = wb.alu_data;
      end
      has_md: begin
        pop = 1'b1;
        sel = head;
      end
      default: ;
    endcase
  end

  // $0 writes retire their slot but never reach the file.
  assign do_wr = (pop || alu_take)
              && (sel.rd != REG_ZERO);
  assign md_wr = pop && (sel.rd != REG_ZERO);

  always_comb begin
    we_d    = do_wr;
    waddr_d = do_wr ? sel.rd   : waddr_q;
    wdata_d = do_wr ? sel.data : wdata_q;
  end

  always_comb begin
    age_d = age_q;
    if (pop || !has_md)
      age_d = '0;
    else if (age_q < AGW'(STARVE_LIMIT))
      age_d = age_q + AGW'(1);
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (wb.iss_valid && wb.iss_rd != REG_ZERO)
      set_vec[wb.iss_rd] = 1'b1;
    if (md_wr)
      clr_vec[sel.rd] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    err_d = err_q;
    if (wb.iss_valid && wb.iss_rd != REG_ZERO
        && busy_q[wb.iss_rd])
      err_d = 1'b1;
    if (pop && !busy_q[head.rd])
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      age_q   <= age_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign wb.rf_we    = we_q;
  assign wb.rf_waddr = waddr_q;
  assign wb.rf_wdata = wdata_q;
  assign wb.busy     = busy_q;
  assign wb.sb_err   = err_q;

endmodule
